// File: rtl/sqrt_bf16_arbiter_pkg.sv
// Shared types and defaults for the bf16 square-root arbiter.
// Imported by the arbiter top and its round-robin sub-module.
package sqrt_arb_pkg;

    localparam int unsigned DEF_NREQ            = 4;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        IDLE   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] operand;
    } sqrt_req_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] result;
    } sqrt_resp_t;

endpackage

// File: rtl/sqrt_bf16_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping modulo NREQ.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [IDW:0] cand;
    logic         found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_i} + (IDW + 1)'(i);
            if (cand >= (IDW + 1)'(NREQ)) begin
                cand = cand - (IDW + 1)'(NREQ);
            end
            if (en_i && !found && req_i[cand[IDW-1:0]]) begin
                found                = 1'b1;
                gnt_o[cand[IDW-1:0]] = 1'b1;
                idx_o                = cand[IDW-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/sqrt_bf16_arbiter.sv
// Shares one in-order sqrt_bf16 core between NREQ requesters; an in-order tag FIFO
// steers each core result back to the requester that issued it.
module sqrt_bf16_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int unsigned NREQ            = DEF_NREQ,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned IDW             = $clog2(NREQ),
    localparam int unsigned CNTW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0][15:0] req_operand,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [15:0]           resp_result,
    input  logic [NREQ-1:0]       resp_ready,
    output logic                  sq_valid_in,
    output logic [15:0]           sq_operand,
    input  logic                  sq_ready_in,
    input  logic                  sq_valid_out,
    input  logic [15:0]           sq_result,
    output logic                  sq_ready_out,
    input  logic                  drain,
    output logic                  idle,
    output logic [CNTW-1:0]       outstanding,
    output logic                  err_orphan
);

    localparam int unsigned     PTRW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTRW-1:0] LAST_SLOT = PTRW'(MAX_OUTSTANDING - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(MAX_OUTSTANDING);
    localparam logic [IDW-1:0]  LAST_REQ  = IDW'(NREQ - 1);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  tag_q [MAX_OUTSTANDING];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_orphan_q, err_orphan_d;

    sqrt_req_t       sq_req;
    sqrt_resp_t      sq_resp;

    logic            fifo_empty, fifo_full;
    logic            issue_en, push, pop;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;
    logic [IDW-1:0]  head;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);

    // drain blocks issue in the very cycle it is raised, not one cycle later
    assign issue_en = (state_q == ACTIVE) && !drain && sq_ready_in && !fifo_full;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (rr_q),
        .en_i    (issue_en),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_vld)
    );

    // Request path: zero-cycle passthrough of the granted operand.
    always_comb begin
        sq_req.valid   = gnt_vld;
        sq_req.operand = gnt_vld ? req_operand[gnt_idx] : 16'h0000;
    end

    assign req_ready   = gnt;
    assign sq_valid_in = sq_req.valid;
    assign sq_operand  = sq_req.operand;
    assign push        = gnt_vld;

    // Response path: route the core result to the requester at the FIFO head.
    assign sq_resp.valid  = sq_valid_out;
    assign sq_resp.result = sq_result;
    assign head           = tag_q[rd_ptr_q];

    always_comb begin
        resp_valid = '0;
        if (sq_resp.valid && !fifo_empty) begin
            resp_valid[head] = 1'b1;
        end
    end

    assign resp_result  = sq_resp.result;
    assign sq_ready_out = !fifo_empty && resp_ready[head];
    assign pop          = sq_resp.valid && sq_ready_out;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign err_orphan_d = err_orphan_q | (sq_resp.valid & fifo_empty);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE:  if (drain) state_d = DRAIN;
            DRAIN:   if (cnt_q == '0) state_d = IDLE;
            IDLE:    if (!drain) state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    always_comb begin
        case (state_q)
            ACTIVE:  idle = fifo_empty && !(|req_valid);
            IDLE:    idle = 1'b1;
            default: idle = 1'b0;
        endcase
    end

    assign outstanding = cnt_q;
    assign err_orphan  = err_orphan_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ACTIVE;
            rr_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset; the count alone says which slots are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            tag_q[wr_ptr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_sqrt_bf16_arbiter.sv
// Directed bench for sqrt_bf16_arbiter with a small in-order core model behind sq_*.
// Inputs change and outputs are sampled around the falling edge.
module tb_sqrt_bf16_arbiter;

    logic             CLK;
    logic             RST;
    logic [3:0]       req_valid;
    logic [3:0][15:0] req_operand;
    logic [3:0]       req_ready;
    logic [3:0]       resp_valid;
    logic [15:0]      resp_result;
    logic [3:0]       resp_ready;
    logic             sq_valid_in;
    logic [15:0]      sq_operand;
    logic             sq_ready_in;
    logic             sq_valid_out;
    logic [15:0]      sq_result;
    logic             sq_ready_out;
    logic             drain;
    logic             idle;
    logic [2:0]       outstanding;
    logic             err_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    sqrt_bf16_arbiter dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_operand  (req_operand),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_result  (resp_result),
        .resp_ready   (resp_ready),
        .sq_valid_in  (sq_valid_in),
        .sq_operand   (sq_operand),
        .sq_ready_in  (sq_ready_in),
        .sq_valid_out (sq_valid_out),
        .sq_result    (sq_result),
        .sq_ready_out (sq_ready_out),
        .drain        (drain),
        .idle         (idle),
        .outstanding  (outstanding),
        .err_orphan   (err_orphan)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Core model: in-order, 8 deep, results valid two cycles after issue.
    function automatic logic [15:0] sqrt_lut(input logic [15:0] x);
        case (x)
            16'h3F80: return 16'h3F80;
            16'h4080: return 16'h4000;
            16'h4110: return 16'h4040;
            16'h4180: return 16'h4080;
            16'h4010: return 16'h3FC0;
            default:  return 16'hFFFF;
        endcase
    endfunction

    logic [15:0] cm_op [16];
    int          cm_t  [16];
    int          cm_head = 0;
    int          cm_tail = 0;
    int          cyc     = 0;
    logic        cm_valid;
    logic        orphan_force;

    assign sq_ready_in  = (cm_tail - cm_head) < 8;
    assign cm_valid     = (cm_tail != cm_head) && (cyc >= cm_t[cm_head % 16]);
    assign sq_valid_out = cm_valid | orphan_force;
    assign sq_result    = cm_valid ? sqrt_lut(cm_op[cm_head % 16]) : 16'h0000;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) begin
            cm_head <= 0;
            cm_tail <= 0;
        end else begin
            if (sq_valid_in && sq_ready_in) begin
                cm_op[cm_tail % 16] <= sq_operand;
                cm_t[cm_tail % 16]  <= cyc + 2;
                cm_tail             <= cm_tail + 1;
            end
            if (cm_valid && sq_ready_out) cm_head <= cm_head + 1;
        end
    end

    // Handshake logs: delivered responses and issued grants.
    int          r_id  [256];
    logic [15:0] r_val [256];
    int          rcnt = 0;
    int          g_id  [256];
    int          gcnt = 0;

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (resp_valid[i] && resp_ready[i]) begin
                r_id[rcnt % 256]  = i;
                r_val[rcnt % 256] = resp_result;
                rcnt              = rcnt + 1;
            end
        end
        if (sq_valid_in && sq_ready_in) begin
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) g_id[gcnt % 256] = i;
            end
            gcnt = gcnt + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_rcnt(input int target, input int budget, output bit ok);
        int c = 0;
        while (rcnt < target && c < budget) begin
            @(negedge CLK);
            c++;
        end
        ok = (rcnt >= target);
    endtask

    task automatic wait_gcnt(input int target, input int budget, output bit ok);
        int c = 0;
        while (gcnt < target && c < budget) begin
            @(negedge CLK);
            c++;
        end
        ok = (gcnt >= target);
    endtask

    task automatic test_reset();
        req_valid    = '0;
        req_operand  = '0;
        resp_ready   = 4'hF;
        drain        = 1'b0;
        orphan_force = 1'b0;
        RST          = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        n_tests++;
        if (outstanding !== 3'd0 || idle !== 1'b1 || err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: outstanding=%0d idle=%b err_orphan=%b, want 0/1/0",
                     outstanding, idle, err_orphan);
        end
        n_tests++;
        if (req_ready !== 4'h0 || resp_valid !== 4'h0 || sq_valid_in !== 1'b0 ||
            sq_ready_out !== 1'b0 || sq_operand !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: req_ready=%b resp_valid=%b sq_valid_in=%b sq_ready_out=%b sq_operand=%h, want all zero",
                     req_ready, resp_valid, sq_valid_in, sq_ready_out, sq_operand);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_single();
        int base;
        bit ok;
        do_reset();
        base           = rcnt;
        req_operand[2] = 16'h4080;
        req_valid      = 4'b0100;
        #1;
        n_tests++;
        if (req_ready !== 4'b0100 || sq_valid_in !== 1'b1 || sq_operand !== 16'h4080) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b sq_valid_in=%b sq_operand=%h, want 0100/1/4080",
                     req_ready, sq_valid_in, sq_operand);
        end
        @(negedge CLK);
        req_valid = '0;
        wait_rcnt(base + 1, 20, ok);
        n_tests++;
        if (!ok || r_id[base % 256] != 2 || r_val[base % 256] !== 16'h4000) begin
            n_fail++;
            $display("FAIL single_resp: ok=%b id=%0d result=%h, want id 2 result 4000",
                     ok, r_id[base % 256], r_val[base % 256]);
        end
        #1;
        n_tests++;
        if (outstanding !== 3'd0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: outstanding=%0d idle=%b, want 0/1", outstanding, idle);
        end
    endtask

    task automatic test_all_four();
        int base;
        bit ok;
        logic [15:0] exp_v [4];
        exp_v[0] = 16'h3F80;
        exp_v[1] = 16'h4000;
        exp_v[2] = 16'h4040;
        exp_v[3] = 16'h4080;
        do_reset();
        base        = rcnt;
        req_operand = {16'h4180, 16'h4110, 16'h4080, 16'h3F80};
        req_valid   = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (req_ready !== 4'(1 << k)) begin
                n_fail++;
                $display("FAIL all4_grant%0d: req_ready=%b, want %b", k, req_ready, 4'(1 << k));
            end
            @(negedge CLK);
            req_valid[k] = 1'b0;
        end
        wait_rcnt(base + 4, 30, ok);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (!ok || r_id[(base + k) % 256] != k || r_val[(base + k) % 256] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL all4_resp%0d: ok=%b id=%0d result=%h, want id %0d result %h",
                         k, ok, r_id[(base + k) % 256], r_val[(base + k) % 256], k, exp_v[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int rbase;
        int gbase;
        bit ok;
        bit stall_bad = 1'b0;
        int exp_id [4];
        logic [15:0] exp_v [4];
        exp_id[0] = 1; exp_v[0] = 16'h3FC0;
        exp_id[1] = 2; exp_v[1] = 16'h4040;
        exp_id[2] = 0; exp_v[2] = 16'h3F80;
        exp_id[3] = 2; exp_v[3] = 16'h4040;
        do_reset();
        rbase       = rcnt;
        gbase       = gcnt;
        resp_ready  = 4'b1101;
        req_operand = {16'h4180, 16'h4110, 16'h4010, 16'h3F80};
        req_valid   = 4'b0010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_first_grant: req_ready=%b, want 0010", req_ready);
        end
        @(negedge CLK);
        req_valid = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (sq_ready_out !== 1'b0) stall_bad = 1'b1;
            @(negedge CLK);
        end
        #1;
        n_tests++;
        if (stall_bad) begin
            n_fail++;
            $display("FAIL bp_stall: sq_ready_out seen 1 while head requester stalled, want 0");
        end
        n_tests++;
        if (outstanding !== 3'd4 || req_ready !== 4'h0 || gcnt - gbase != 4) begin
            n_fail++;
            $display("FAIL bp_full: outstanding=%0d req_ready=%b issues=%0d, want 4/0000/4",
                     outstanding, req_ready, gcnt - gbase);
        end
        n_tests++;
        if (resp_valid !== 4'b0010 || resp_result !== 16'h3FC0) begin
            n_fail++;
            $display("FAIL bp_head: resp_valid=%b resp_result=%h, want 0010/3FC0",
                     resp_valid, resp_result);
        end
        req_valid  = '0;
        resp_ready = 4'hF;
        wait_rcnt(rbase + 4, 30, ok);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (!ok || r_id[(rbase + k) % 256] != exp_id[k] ||
                r_val[(rbase + k) % 256] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL bp_order%0d: ok=%b id=%0d result=%h, want id %0d result %h", k, ok,
                         r_id[(rbase + k) % 256], r_val[(rbase + k) % 256], exp_id[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_fairness();
        int gbase;
        int rbase;
        bit ok;
        bit alt_bad = 1'b0;
        do_reset();
        gbase          = gcnt;
        rbase          = rcnt;
        req_operand[0] = 16'h3F80;
        req_operand[3] = 16'h4180;
        req_valid      = 4'b1001;
        wait_gcnt(gbase + 8, 60, ok);
        req_valid = '0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fair_issue: issued=%0d, want 8", gcnt - gbase);
        end
        for (int j = 0; j < 8; j++) begin
            n_tests++;
            if (g_id[(gbase + j) % 256] != ((j % 2 == 0) ? 0 : 3)) begin
                n_fail++;
                $display("FAIL fair_grant%0d: granted %0d, want %0d", j, g_id[(gbase + j) % 256],
                         (j % 2 == 0) ? 0 : 3);
            end
        end
        wait_rcnt(rbase + 8, 40, ok);
        for (int j = 0; j < 8; j++) begin
            if (r_id[(rbase + j) % 256] != ((j % 2 == 0) ? 0 : 3) ||
                r_val[(rbase + j) % 256] !== ((j % 2 == 0) ? 16'h3F80 : 16'h4080)) alt_bad = 1'b1;
        end
        n_tests++;
        if (!ok || alt_bad) begin
            n_fail++;
            $display("FAIL fair_resp: ok=%b order_bad=%b, want responses 0,3,0,3 with 3F80/4080",
                     ok, alt_bad);
        end
    endtask

    task automatic test_drain();
        int gbase;
        int rbase;
        bit ok;
        bit issue_bad = 1'b0;
        int c;
        do_reset();
        gbase       = gcnt;
        resp_ready  = 4'h0;
        req_operand = {16'h4180, 16'h4110, 16'h4080, 16'h3F80};
        req_valid   = 4'b0111;
        wait_gcnt(gbase + 3, 20, ok);
        drain     = 1'b1;
        req_valid = 4'b1000;
        #1;
        n_tests++;
        if (!ok || outstanding !== 3'd3 || req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL drain_start: ok=%b outstanding=%0d req_ready=%b, want 3/0000",
                     ok, outstanding, req_ready);
        end
        rbase = rcnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            if (req_ready !== 4'h0) issue_bad = 1'b1;
        end
        resp_ready = 4'hF;
        c = 0;
        while (rcnt < rbase + 3 && c < 20) begin
            @(negedge CLK);
            #1;
            if (req_ready !== 4'h0) issue_bad = 1'b1;
            c++;
        end
        n_tests++;
        if (rcnt < rbase + 3 || outstanding !== 3'd0 || idle !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_last_pop: pops=%0d outstanding=%0d idle=%b, want 3/0/0",
                     rcnt - rbase, outstanding, idle);
        end
        @(negedge CLK);
        #1;
        n_tests++;
        if (idle !== 1'b1 || req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL drain_idle: idle=%b req_ready=%b, want 1/0000", idle, req_ready);
        end
        n_tests++;
        if (issue_bad) begin
            n_fail++;
            $display("FAIL drain_no_issue: req_ready seen nonzero while draining, want 0000");
        end
        drain = 1'b0;
        c     = 0;
        while (req_ready !== 4'b1000 && c < 4) begin
            @(negedge CLK);
            #1;
            c++;
        end
        n_tests++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL drain_resume: req_ready=%b, want 1000", req_ready);
        end
        @(negedge CLK);
        req_valid = '0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int gbase;
        int rbase;
        bit ok;
        bit resp_seen = 1'b0;
        do_reset();
        gbase       = gcnt;
        resp_ready  = 4'h0;
        req_operand = {16'h4180, 16'h4110, 16'h4080, 16'h3F80};
        req_valid   = 4'b0011;
        wait_gcnt(gbase + 2, 20, ok);
        req_valid = '0;
        #1;
        n_tests++;
        if (!ok || outstanding !== 3'd2) begin
            n_fail++;
            $display("FAIL rstmid_pre: ok=%b outstanding=%0d, want 2", ok, outstanding);
        end
        do_reset();
        #1;
        n_tests++;
        if (outstanding !== 3'd0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_post: outstanding=%0d idle=%b, want 0/1", outstanding, idle);
        end
        rbase      = rcnt;
        resp_ready = 4'hF;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            #1;
            if (resp_valid !== 4'h0) resp_seen = 1'b1;
        end
        n_tests++;
        if (resp_seen || rcnt != rbase) begin
            n_fail++;
            $display("FAIL rstmid_no_resp: resp_valid seen=%b deliveries=%0d, want 0/0",
                     resp_seen, rcnt - rbase);
        end
    endtask

    task automatic test_orphan();
        bit sticky_bad = 1'b0;
        do_reset();
        orphan_force = 1'b1;
        #1;
        n_tests++;
        if (sq_ready_out !== 1'b0 || resp_valid !== 4'h0 || err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_cycle: sq_ready_out=%b resp_valid=%b err_orphan=%b, want 0/0000/0",
                     sq_ready_out, resp_valid, err_orphan);
        end
        @(negedge CLK);
        orphan_force = 1'b0;
        #1;
        n_tests++;
        if (err_orphan !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_set: err_orphan=%b, want 1", err_orphan);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            #1;
            if (err_orphan !== 1'b1) sticky_bad = 1'b1;
        end
        n_tests++;
        if (sticky_bad) begin
            n_fail++;
            $display("FAIL orphan_sticky: err_orphan dropped before reset, want 1");
        end
        do_reset();
        #1;
        n_tests++;
        if (err_orphan !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_clear: err_orphan=%b after reset, want 0", err_orphan);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_drain();
        test_reset_mid();
        test_orphan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
